// File: rtl/imm_encoder.sv
// Immediate encoder: inserts a 32-bit immediate into the I/S/B/J/U fields of a base
// instruction word and flags unrepresentable values; two-stage valid/ready pipeline.
module imm_encoder #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_ctrl,
    input  logic [31:0]          in_base,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0] IMM_ITYPE = 3'd0;
    localparam logic [2:0] IMM_STYPE = 3'd1;
    localparam logic [2:0] IMM_BTYPE = 3'd2;
    localparam logic [2:0] IMM_JTYPE = 3'd3;
    localparam logic [2:0] IMM_UTYPE = 3'd4;

    logic                 s1_valid_q, s1_valid_d;
    logic [2:0]           s1_ctrl_q, s1_ctrl_d;
    logic [31:0]          s1_base_q, s1_base_d;
    logic [31:0]          s1_imm_q, s1_imm_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          out_instr_q, out_instr_d;
    logic                 out_err_q, out_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic        s1_adv, s2_adv;
    logic        fit_12b, fit_13b, fit_21b;
    logic [31:0] enc_instr;
    logic        enc_err;

    // An upper slice that is all-zeros or all-ones is a valid sign extension.
    always_comb begin
        fit_12b = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
        fit_13b = (&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]);
        fit_21b = (&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]);
    end

    always_comb begin
        enc_instr = s1_base_q;
        enc_err   = 1'b0;
        case (s1_ctrl_q)
            IMM_ITYPE: begin
                enc_instr[31:20] = s1_imm_q[11:0];
                enc_err          = ~fit_12b;
            end
            IMM_STYPE: begin
                enc_instr[31:25] = s1_imm_q[11:5];
                enc_instr[11:7]  = s1_imm_q[4:0];
                enc_err          = ~fit_12b;
            end
            IMM_BTYPE: begin
                enc_instr[31]    = s1_imm_q[12];
                enc_instr[7]     = s1_imm_q[11];
                enc_instr[30:25] = s1_imm_q[10:5];
                enc_instr[11:8]  = s1_imm_q[4:1];
                enc_err          = ~fit_13b | s1_imm_q[0];
            end
            IMM_JTYPE: begin
                enc_instr[31]    = s1_imm_q[20];
                enc_instr[19:12] = s1_imm_q[19:12];
                enc_instr[20]    = s1_imm_q[11];
                enc_instr[30:21] = s1_imm_q[10:1];
                enc_err          = ~fit_21b | s1_imm_q[0];
            end
            IMM_UTYPE: begin
                enc_instr[31:12] = s1_imm_q[31:12];
                enc_err          = |s1_imm_q[11:0];
            end
            default: enc_err = 1'b1;
        endcase
    end

    always_comb begin
        s2_adv = ~s2_valid_q | out_ready;
        s1_adv = ~s1_valid_q | s2_adv;

        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s1_ctrl_d  = s1_ctrl_q;
        s1_base_d  = s1_base_q;
        s1_imm_d   = s1_imm_q;
        if (s1_adv && in_valid) begin
            s1_ctrl_d = in_ctrl;
            s1_base_d = in_base;
            s1_imm_d  = in_imm;
        end

        s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        if (s2_adv && s1_valid_q) begin
            out_instr_d = enc_instr;
            out_err_d   = enc_err;
        end

        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (s2_valid_q && out_ready && out_err_q && !(&err_count_q)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_ctrl_q   <= '0;
            s1_base_q   <= '0;
            s1_imm_q    <= '0;
            s2_valid_q  <= 1'b0;
            out_instr_q <= '0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ctrl_q   <= s1_ctrl_d;
            s1_base_q   <= s1_base_d;
            s1_imm_q    <= s1_imm_d;
            s2_valid_q  <= s2_valid_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule
